// File: rtl/pwm_peripheral.sv
// 16-pin PWM output stage: each pin forced low, static high, or PWM at a shared shadowed 8-bit duty.
// Latency: enable changes reach out 1 clk later; duty changes apply at the next period start, out 1 clk after load.
// Backpressure: none, inputs are quasi-static register values and are sampled every clk.
module pwm_peripheral #(
   parameter int CLK_DIV = 13
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] en_out,
   input  logic [15:0] en_pwm,
   input  logic [7:0]  pwm_duty,
   output logic [15:0] out,
   output logic        period_start
);

   // Prescaler width must hold CLK_DIV-1; keep at least one bit so CLK_DIV=1 still elaborates.
   localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);

   logic [PW-1:0] r_presc;
   logic [7:0]    r_cnt;
   logic [7:0]    r_duty_sh;
   logic [15:0]   r_out;
   logic          r_period_start;

   logic          w_tick;
   logic          w_load;
   logic [7:0]    w_duty;
   logic          w_pwm;
   logic [15:0]   w_out_nxt;

   // Period timing and the shared PWM level; on the load cycle the fresh duty is used directly
   // so the very first counter value of a period already reflects the new duty.
   always_comb begin
      w_tick    = (r_presc == PRESC_LAST);
      w_load    = (r_presc == '0) && (r_cnt == 8'd0);
      w_duty    = w_load ? pwm_duty : r_duty_sh;
      // 0xFF is treated as a true 100% so there is no one-tick dip at cnt=255.
      w_pwm     = (w_duty == 8'hFF) | (r_cnt < w_duty);
      // Disabled pins are low regardless of PWM select; enabled non-PWM pins are static high.
      w_out_nxt = en_out & (~en_pwm | {16{w_pwm}});
   end

   // Prescaler: counts 0..CLK_DIV-1 and wraps, never exceeding its terminal value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_presc <= '0;
      end else if (w_tick) begin
         r_presc <= '0;
      end else begin
         r_presc <= r_presc + PW'(1);
      end
   end

   // Period counter: advances once per prescaler tick, natural 8-bit wrap 255 -> 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= 8'd0;
      end else if (w_tick) begin
         r_cnt <= r_cnt + 8'd1;
      end
   end

   // Duty shadow: captured only at period start so mid-period writes cannot glitch the waveform.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_duty_sh <= 8'h00;
      end else if (w_load) begin
         r_duty_sh <= pwm_duty;
      end
   end

   // Registered pin outputs and period marker, aligned to the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out          <= 16'h0000;
         r_period_start <= 1'b0;
      end else begin
         r_out          <= w_out_nxt;
         r_period_start <= w_load;
      end
   end

   assign out          = r_out;
   assign period_start = r_period_start;

endmodule

// File: tb/tb_pwm_peripheral.sv
module tb_pwm_peripheral;

   localparam int CLK_DIV = 13;
   localparam int PERIOD  = 256 * CLK_DIV;

   logic        clk;
   logic        rst_n;
   logic [15:0] en_out;
   logic [15:0] en_pwm;
   logic [7:0]  pwm_duty;
   logic [15:0] out;
   logic        period_start;

   int checks = 0;
   int errors = 0;

   pwm_peripheral #(.CLK_DIV(CLK_DIV)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .en_out       (en_out),
      .en_pwm       (en_pwm),
      .pwm_duty     (pwm_duty),
      .out          (out),
      .period_start (period_start)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance one clock; sample/drive 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reset and release; returns in the first cycle of the new period (period_start expected high).
   task automatic do_reset();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      step();
   endtask

   // Observe one full period from the current period-start cycle, optionally changing duty at cycle chg_at.
   // Ends positioned at the cycle where the next period_start is expected.
   task automatic run_period(input int chg_at, input logic [7:0] new_duty,
                             output int hi, output int first_low, output int extra_ps);
      hi        = 0;
      first_low = PERIOD;
      extra_ps  = 0;
      for (int n = 0; n < PERIOD; n++) begin
         if (out[0] === 1'b1) hi++;
         else if (first_low == PERIOD) first_low = n;
         if (n > 0 && period_start !== 1'b0) extra_ps++;
         if (n == chg_at) pwm_duty = new_duty;
         step();
      end
   endtask

   task automatic test_reset();
      rst_n    = 1'b0;
      en_out   = 16'hFFFF;
      en_pwm   = 16'h0000;
      pwm_duty = 8'h00;
      step();
      step();
      checks++;
      if (out !== 16'h0000) begin
         errors++;
         $display("FAIL reset_out: got %h expected 0000", out);
      end
      checks++;
      if (period_start !== 1'b0) begin
         errors++;
         $display("FAIL reset_ps: got %b expected 0", period_start);
      end
      rst_n = 1'b1;
      step();
      checks++;
      if (out !== 16'hFFFF) begin
         errors++;
         $display("FAIL release_out: got %h expected ffff", out);
      end
      checks++;
      if (period_start !== 1'b1) begin
         errors++;
         $display("FAIL release_ps_high: got %b expected 1", period_start);
      end
      step();
      checks++;
      if (period_start !== 1'b0) begin
         errors++;
         $display("FAIL release_ps_low: got %b expected 0", period_start);
      end
   endtask

   task automatic test_static_gating();
      en_out   = 16'h00F0;
      en_pwm   = 16'h0030;
      pwm_duty = 8'h00;
      step();
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (out !== 16'h00C0) begin
            errors++;
            $display("FAIL static_out[%0d]: got %h expected 00c0", i, out);
         end
         step();
      end
      en_out = 16'h0070;
      step();
      checks++;
      if (out !== 16'h0040) begin
         errors++;
         $display("FAIL gate_bit7: got %h expected 0040", out);
      end
   endtask

   task automatic test_duty_50();
      int hi, fl, xps;
      en_out   = 16'h0001;
      en_pwm   = 16'h0001;
      pwm_duty = 8'h80;
      do_reset();
      checks++;
      if (period_start !== 1'b1 || out[0] !== 1'b1) begin
         errors++;
         $display("FAIL d50_rise: got ps=%b out0=%b expected 1/1", period_start, out[0]);
      end
      run_period(-1, 8'h00, hi, fl, xps);
      checks++;
      if (hi !== 1664 || fl !== 1664) begin
         errors++;
         $display("FAIL d50_high: got hi=%0d first_low=%0d expected 1664/1664", hi, fl);
      end
      checks++;
      if (xps !== 0 || period_start !== 1'b1) begin
         errors++;
         $display("FAIL d50_period: got extra=%0d ps_end=%b expected 0/1", xps, period_start);
      end
      checks++;
      if (out !== 16'h0001) begin
         errors++;
         $display("FAIL d50_next_rise: got %h expected 0001", out);
      end
   endtask

   task automatic test_extremes();
      int hi, fl, xps;
      pwm_duty = 8'hFF;
      do_reset();
      for (int p = 0; p < 3; p++) begin
         run_period(-1, 8'h00, hi, fl, xps);
         checks++;
         if (hi !== PERIOD || xps !== 0 || period_start !== 1'b1) begin
            errors++;
            $display("FAIL dff_p%0d: got hi=%0d extra=%0d ps=%b expected %0d/0/1",
                     p, hi, xps, period_start, PERIOD);
         end
      end
      pwm_duty = 8'h01;
      do_reset();
      run_period(-1, 8'h00, hi, fl, xps);
      checks++;
      if (hi !== 13 || fl !== 13) begin
         errors++;
         $display("FAIL d01_high: got hi=%0d first_low=%0d expected 13/13", hi, fl);
      end
   endtask

   task automatic test_shadow();
      int hi, fl, xps;
      pwm_duty = 8'h40;
      do_reset();
      run_period(500, 8'hC0, hi, fl, xps);
      checks++;
      if (hi !== 832 || fl !== 832) begin
         errors++;
         $display("FAIL shadow_cur: got hi=%0d first_low=%0d expected 832/832", hi, fl);
      end
      checks++;
      if (period_start !== 1'b1) begin
         errors++;
         $display("FAIL shadow_ps: got %b expected 1", period_start);
      end
      run_period(-1, 8'h00, hi, fl, xps);
      checks++;
      if (hi !== 2496 || fl !== 2496) begin
         errors++;
         $display("FAIL shadow_next: got hi=%0d first_low=%0d expected 2496/2496", hi, fl);
      end
   endtask

   task automatic test_async_reset();
      int hi, fl, xps;
      pwm_duty = 8'hC0;
      do_reset();
      // Walk to cnt=50, change duty (shadowed), then on to cnt~100 where the pin is still high.
      for (int n = 0; n < 1300; n++) begin
         if (n == 650) pwm_duty = 8'h20;
         step();
      end
      checks++;
      if (out !== 16'h0001) begin
         errors++;
         $display("FAIL pre_reset_out: got %h expected 0001", out);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (out !== 16'h0000 || period_start !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: got out=%h ps=%b expected 0000/0", out, period_start);
      end
      step();
      rst_n = 1'b1;
      step();
      checks++;
      if (period_start !== 1'b1) begin
         errors++;
         $display("FAIL restart_ps: got %b expected 1", period_start);
      end
      run_period(-1, 8'h00, hi, fl, xps);
      checks++;
      if (hi !== 416 || fl !== 416) begin
         errors++;
         $display("FAIL restart_high: got hi=%0d first_low=%0d expected 416/416", hi, fl);
      end
   endtask

   initial begin
      rst_n    = 1'b0;
      en_out   = 16'h0000;
      en_pwm   = 16'h0000;
      pwm_duty = 8'h00;
      test_reset();
      test_static_gating();
      test_duty_50();
      test_extremes();
      test_shadow();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pwm_peripheral.md
Name: pwm_peripheral

Overview:
- Consumes the five SPI-written control registers and drives 16 output pins.
- Each pin is one of: forced low, static high, or PWM at a shared 8-bit duty cycle.
- Contains a clock prescaler, an 8-bit period counter and a duty shadow register, so duty changes only take effect at period boundaries (no glitches).
- Sits directly downstream of the SPI register block; all inputs are treated as quasi-static and synchronous to clk.

Parameters:
- CLK_DIV, 13: clk cycles per PWM counter tick; legal range 1..4095. PWM period = 256*CLK_DIV clk cycles (≈3 kHz at a 10 MHz clk).

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- en_out  input  16  per-pin output enable ({reg_1, reg_0})
- en_pwm  input  16  per-pin PWM select ({reg_3, reg_2})
- pwm_duty  input  8  shared duty cycle (reg_4)
- out  output  16  output pins, registered
- period_start  output  1  one-cycle pulse, registered, at the start of each PWM period

Behaviour:
- Reset values (async on rst_n low): presc=0, cnt=0, duty_sh=0x00, out=16'h0000, period_start=0.
- Prescaler presc counts 0..CLK_DIV-1 every clk and wraps to 0.
- tick = (presc==CLK_DIV-1). With CLK_DIV=1, tick is high every cycle.
- Counter cnt (8 bit) increments on tick and wraps 255 -> 0; otherwise it holds.
- Load condition: load = (presc==0 && cnt==0). This is true in the first clk after reset release and then once per period.
- On load: duty_sh <= pwm_duty. pwm_duty is ignored at all other times.
- Effective duty: d = load ? pwm_duty : duty_sh.
- PWM level: pwm = (d==8'hFF) | (cnt < d).
  - d=0x00 -> always low.
  - d=0xFF -> always high (100%, no one-tick dip).
  - otherwise high for d*CLK_DIV clk cycles per period, starting at the period start.
- Per-pin next output: out[i] <= en_out[i] ? (en_pwm[i] ? pwm : 1) : 0.
  - en_out=0 dominates regardless of en_pwm.
  - en_out=1 with en_pwm=0 gives static high.
- Latency:
  - en_out/en_pwm changes reach out on the next clk edge (1 cycle); they are not shadowed.
  - Duty changes take effect at the next load condition; output follows 1 cycle after load.
- period_start <= load. It asserts for exactly 1 cycle, aligned with the first cycle of out reflecting the new period.
- All 16 PWM pins share the same phase (cnt) and are edge-aligned; no per-pin skew.
- Reset mid-period: everything returns to reset values immediately (out low asynchronously). After release the period restarts at cnt=0 with a fresh duty load.
- Boundary (last cycle of a period): at cnt=255, presc=CLK_DIV-1, the next cycle is presc=0, cnt=0, i.e. a load.
- The width of presc must hold CLK_DIV-1. Counters never exceed their terminal values.

Test Plan:
- Reset: hold rst_n low with en_out=16'hFFFF, en_pwm=0 -> out=0, period_start=0. Release -> out=16'hFFFF after 1 clk, period_start pulses 1 cycle.
- Static/gating: en_out=16'h00F0, en_pwm=16'h0030, duty=0x00 -> out=16'h00C0 constant. Clear en_out[7] -> out[7]=0 on the next clk.
- 50% duty (CLK_DIV=13): en_out=en_pwm=16'h0001, duty=0x80 -> out[0] high 1664 cycles then low 1664 cycles; period_start every 3328 cycles, coinciding with the rising edge.
- Extremes: duty=0xFF -> out[0] never drops across 3 periods. duty=0x01 -> out[0] high exactly 13 cycles per period.
- Shadowing: change duty 0x40 -> 0xC0 mid-period -> current period keeps 832-cycle high time; next period (after the period_start pulse) has 2496-cycle high time.
- Async reset at cnt≈100 -> out=0 immediately. After release, cnt restarts at 0 and the next period's high time matches the current pwm_duty.
